// File: rtl/eth_tx_framer_pkg.sv
// Shared constants for the Ethernet transmit framer: GMII framing bytes,
// descriptor field positions and the CRC-32 byte-step helper.
package eth_tx_framer_pkg;

    localparam logic [7:0] ETH_PREAMBLE = 8'h55;
    localparam logic [7:0] ETH_SFD      = 8'hD5;

    localparam int DESC_FLUSH  = 31;
    localparam int DESC_FB_HI  = 23;
    localparam int DESC_FB_LO  = 16;
    localparam int DESC_CNT_HI = 11;
    localparam int DESC_CNT_LO = 0;

    localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_POLY_REFL = 32'hEDB88320;
    localparam logic [31:0] CRC_RESIDUE   = 32'hC704DD7B;

    // Reflected CRC-32, one byte per call, data bits taken LSB first.
    function automatic logic [31:0] crc32_step(input logic [31:0] crc_in,
                                               input logic [7:0]  din);
        logic [31:0] c;
        c = crc_in ^ {24'h000000, din};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY_REFL) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/eth_tx_framer_crc.sv
// Byte-wide registered CRC-32 (IEEE 802.3, reflected) used for the frame FCS.
module eth_crc32_d8
    import eth_tx_framer_pkg::*;
(
    input  logic        clk,
    input  logic        init,
    input  logic        en,
    input  logic [7:0]  din,
    output logic [31:0] crc
);

    logic [31:0] crc_q;

    always_ff @(posedge clk) begin
        if (init) begin
            crc_q <= CRC_INIT;
        end else if (en) begin
            crc_q <= crc32_step(crc_q, din);
        end
    end

    assign crc = crc_q;

endmodule

// File: rtl/eth_tx_framer.sv
// GMII transmit framer: descriptor + payload FIFOs in, preamble/SFD/payload/pad/FCS/IFG out.
// Optional statistics output tx_stats is enabled by defining ETH_TX_STATS_EN.
module eth_tx_framer
    import eth_tx_framer_pkg::*;
#(
    parameter int MIN_PAYLOAD = 60,
    parameter int IFG_CYCLES  = 12,
    parameter int CNT_W       = 12
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic        send_info_empty,
    input  logic [31:0] send_info_dout,
    output logic        send_info_rd_en,
    input  logic        send_fifo_empty,
    input  logic [15:0] send_fifo_dout,
    output logic        send_rd_en,
    output logic [7:0]  gmii_txd,
    output logic        gmii_tx_en,
    output logic        gmii_tx_er,
    output logic        tx_busy,
    input  logic        clearErrors,
`ifdef ETH_TX_STATS_EN
    output logic [31:0] tx_stats,
`endif
    output logic        first_byte_error,
    output logic        underrun_error
);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_FLUSH    = 3'd1;
    localparam logic [2:0] ST_PREAMBLE = 3'd2;
    localparam logic [2:0] ST_SFD      = 3'd3;
    localparam logic [2:0] ST_DATA     = 3'd4;
    localparam logic [2:0] ST_PAD      = 3'd5;
    localparam logic [2:0] ST_FCS      = 3'd6;
    localparam logic [2:0] ST_IFG      = 3'd7;

    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(6);
    localparam logic [CNT_W-1:0] MIN_P    = CNT_W'(MIN_PAYLOAD);
    localparam logic [CNT_W-1:0] PAD_LAST = CNT_W'(MIN_PAYLOAD - 1);
    // The IDLE cycle that follows supplies the final idle byte-time of the gap.
    localparam logic [CNT_W-1:0] IFG_LAST = CNT_W'(IFG_CYCLES - 2);

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] popped_q, popped_d;
    logic [CNT_W-1:0] nbytes_q, nbytes_d;
    logic [CNT_W-1:0] nwords_q, nwords_d;
    logic [7:0]       fb_q, fb_d;
    logic             underrun_q, underrun_d;
    logic             fbe_q, fbe_d;
    logic             ure_q, ure_d;

    logic [CNT_W-1:0] desc_cnt;
    logic [CNT_W:0]   nb_plus1;
    logic [7:0]       byte_sel;
    logic [31:0]      crc;
    logic [31:0]      fcs;
    logic             avail, last_byte;
    logic             info_pop, data_pop;
    logic             crc_init, crc_en;
    logic             fbe_set, ure_set;
    logic             unused_bits;

    assign desc_cnt    = CNT_W'(send_info_dout[DESC_CNT_HI:DESC_CNT_LO]);
    assign nb_plus1    = {1'b0, desc_cnt} + {{CNT_W{1'b0}}, 1'b1};
    assign byte_sel    = cnt_q[0] ? send_fifo_dout[7:0] : send_fifo_dout[15:8];
    assign avail       = !send_fifo_empty && !underrun_q;
    assign last_byte   = (cnt_q == nbytes_q - ONE);
    assign fcs         = ~crc;
    assign unused_bits = ^{send_info_dout[30:24], send_info_dout[15:12], nb_plus1[0]};

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        popped_d   = popped_q;
        nbytes_d   = nbytes_q;
        nwords_d   = nwords_q;
        fb_d       = fb_q;
        underrun_d = underrun_q;
        gmii_txd   = 8'h00;
        gmii_tx_en = 1'b0;
        gmii_tx_er = 1'b0;
        info_pop   = 1'b0;
        data_pop   = 1'b0;
        crc_init   = 1'b0;
        crc_en     = 1'b0;
        fbe_set    = 1'b0;
        ure_set    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!send_info_empty) begin
                    info_pop   = 1'b1;
                    nbytes_d   = desc_cnt;
                    nwords_d   = nb_plus1[CNT_W:1];
                    fb_d       = send_info_dout[DESC_FB_HI:DESC_FB_LO];
                    popped_d   = '0;
                    underrun_d = 1'b0;
                    cnt_d      = '0;
                    state_d    = send_info_dout[DESC_FLUSH] ? ST_FLUSH : ST_PREAMBLE;
                end
            end
            ST_FLUSH: begin
                if (popped_q >= nwords_q) begin
                    state_d = ST_IDLE;
                end else if (!send_fifo_empty) begin
                    data_pop = 1'b1;
                    popped_d = popped_q + ONE;
                    if (popped_q + ONE == nwords_q) state_d = ST_IDLE;
                end
            end
            ST_PREAMBLE: begin
                gmii_tx_en = 1'b1;
                gmii_txd   = ETH_PREAMBLE;
                if (cnt_q == PRE_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_SFD;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            ST_SFD: begin
                gmii_tx_en = 1'b1;
                gmii_txd   = ETH_SFD;
                crc_init   = 1'b1;
                cnt_d      = '0;
                state_d    = (nbytes_q == '0) ? ST_PAD : ST_DATA;
            end
            ST_DATA: begin
                gmii_tx_en = 1'b1;
                crc_en     = 1'b1;
                if (avail) begin
                    gmii_txd = byte_sel;
                    // Odd bytes, and the lone high byte of an odd-length tail, retire the word.
                    if (cnt_q[0] || last_byte) begin
                        data_pop = 1'b1;
                        popped_d = popped_q + ONE;
                    end
                    if (cnt_q == '0 && byte_sel != fb_q) fbe_set = 1'b1;
                end else begin
                    gmii_tx_er = 1'b1;
                    underrun_d = 1'b1;
                    ure_set    = 1'b1;
                end
                cnt_d = cnt_q + ONE;
                if (last_byte) begin
                    if (nbytes_q < MIN_P) begin
                        state_d = ST_PAD;
                    end else begin
                        cnt_d   = '0;
                        state_d = ST_FCS;
                    end
                end
            end
            ST_PAD: begin
                gmii_tx_en = 1'b1;
                crc_en     = 1'b1;
                if (cnt_q >= PAD_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_FCS;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            ST_FCS: begin
                gmii_tx_en = 1'b1;
                case (cnt_q[1:0])
                    2'd0:    gmii_txd = fcs[7:0];
                    2'd1:    gmii_txd = fcs[15:8];
                    2'd2:    gmii_txd = fcs[23:16];
                    default: gmii_txd = fcs[31:24];
                endcase
                if (cnt_q[1:0] == 2'd3) begin
                    cnt_d   = '0;
                    state_d = ST_IFG;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            ST_IFG: begin
                if (cnt_q >= IFG_LAST) begin
                    cnt_d   = '0;
                    state_d = underrun_q ? ST_FLUSH : ST_IDLE;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        fbe_d = fbe_set ? 1'b1 : (clearErrors ? 1'b0 : fbe_q);
        ure_d = ure_set ? 1'b1 : (clearErrors ? 1'b0 : ure_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            popped_q   <= '0;
            underrun_q <= 1'b0;
            fbe_q      <= 1'b0;
            ure_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            popped_q   <= popped_d;
            underrun_q <= underrun_d;
            fbe_q      <= fbe_d;
            ure_q      <= ure_d;
        end
    end

    always_ff @(posedge clk) begin
        nbytes_q <= nbytes_d;
        nwords_q <= nwords_d;
        fb_q     <= fb_d;
    end

    eth_crc32_d8 u_crc (
        .clk  (clk),
        .init (crc_init),
        .en   (crc_en),
        .din  (gmii_txd),
        .crc  (crc)
    );

    // FIFO pops are suppressed while reset is held so queued words survive.
    assign send_info_rd_en  = info_pop && !reset;
    assign send_rd_en       = data_pop && !reset;
    assign tx_busy          = (state_q != ST_IDLE);
    assign first_byte_error = fbe_q;
    assign underrun_error   = ure_q;

`ifdef ETH_TX_STATS_EN
    logic [15:0] num_sent_q;
    logic [7:0]  num_under_q;
    logic [7:0]  num_flush_q;
    logic        sent_inc, under_inc, flush_inc;

    assign sent_inc  = (state_q == ST_FCS) && (cnt_q[1:0] == 2'd3);
    assign under_inc = (state_q == ST_DATA) && send_fifo_empty && !underrun_q;
    assign flush_inc = (state_q == ST_IDLE) && !send_info_empty && send_info_dout[DESC_FLUSH];

    always_ff @(posedge clk) begin
        if (reset) begin
            num_sent_q  <= '0;
            num_under_q <= '0;
            num_flush_q <= '0;
        end else begin
            if (sent_inc)  num_sent_q  <= num_sent_q + 16'd1;
            if (under_inc) num_under_q <= num_under_q + 8'd1;
            if (flush_inc) num_flush_q <= num_flush_q + 8'd1;
        end
    end

    assign tx_stats = {num_flush_q, num_under_q, num_sent_q};
`endif

endmodule

// File: tb/tb_eth_tx_framer.sv
// Directed table-driven bench for eth_tx_framer with FWFT FIFO models and a CRC residue check.
module tb_eth_tx_framer;

    typedef struct {
        logic [31:0] desc;
        int          nwords;
        logic [15:0] w0;
        logic [15:0] w1;
        logic [15:0] w2;
        int          exp_len;
        int          exp_pops;
        logic        exp_fbe;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        send_info_empty;
    logic [31:0] send_info_dout;
    logic        send_info_rd_en;
    logic        send_fifo_empty;
    logic [15:0] send_fifo_dout;
    logic        send_rd_en;
    logic [7:0]  gmii_txd;
    logic        gmii_tx_en;
    logic        gmii_tx_er;
    logic        tx_busy;
    logic        clearErrors;
    logic        first_byte_error;
    logic        underrun_error;
`ifdef ETH_TX_STATS_EN
    logic [31:0] tx_stats;
`endif

    eth_tx_framer dut (
        .clk              (clk),
        .reset            (reset),
        .send_info_empty  (send_info_empty),
        .send_info_dout   (send_info_dout),
        .send_info_rd_en  (send_info_rd_en),
        .send_fifo_empty  (send_fifo_empty),
        .send_fifo_dout   (send_fifo_dout),
        .send_rd_en       (send_rd_en),
        .gmii_txd         (gmii_txd),
        .gmii_tx_en       (gmii_tx_en),
        .gmii_tx_er       (gmii_tx_er),
        .tx_busy          (tx_busy),
        .clearErrors      (clearErrors),
`ifdef ETH_TX_STATS_EN
        .tx_stats         (tx_stats),
`endif
        .first_byte_error (first_byte_error),
        .underrun_error   (underrun_error)
    );

    always #4 clk = ~clk;

    logic [15:0] dq[$];
    logic [31:0] iq[$];
    logic [15:0] sent_words[$];
    logic [7:0]  cap[$];
    logic        er_cap[$];
    int          rises[$];
    int          n_vec = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          pops = 0;
    int          ipops = 0;
    logic        dpop = 1'b0;
    logic        ipop = 1'b0;
    logic        prev_en = 1'b0;
    vec_t        vecs[6];

    task automatic refresh();
        send_fifo_empty = (dq.size() == 0);
        send_fifo_dout  = (dq.size() == 0) ? 16'h0000 : dq[0];
        send_info_empty = (iq.size() == 0);
        send_info_dout  = (iq.size() == 0) ? 32'h0 : iq[0];
    endtask

    // Monitor samples mid-cycle, FIFO models retire popped entries just after the edge.
    always @(negedge clk) begin
        cyc++;
        dpop = send_rd_en;
        ipop = send_info_rd_en;
        if (send_rd_en) pops++;
        if (send_info_rd_en) ipops++;
        if (gmii_tx_en) begin
            cap.push_back(gmii_txd);
            er_cap.push_back(gmii_tx_er);
            if (!prev_en) rises.push_back(cyc);
        end
        prev_en = gmii_tx_en;
    end

    always @(posedge clk) begin
        #1;
        if (dpop && dq.size() > 0) void'(dq.pop_front());
        if (ipop && iq.size() > 0) void'(iq.pop_front());
        refresh();
    end

    task automatic sync();
        @(posedge clk);
        #2;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic push_word(input logic [15:0] w);
        dq.push_back(w);
        sent_words.push_back(w);
        refresh();
    endtask

    task automatic clear_cap();
        cap.delete();
        er_cap.delete();
        rises.delete();
        sent_words.delete();
        pops  = 0;
        ipops = 0;
    endtask

    task automatic wait_idle(input string name);
        bit seen = 1'b0;
        bit done = 1'b0;
        for (int i = 0; i < 2000 && !done; i++) begin
            sync();
            if (tx_busy) seen = 1'b1;
            else if (seen) done = 1'b1;
        end
        if (!done) begin
            n_vec++;
            n_bad++;
            $display("FAIL %s timeout: busy=%0b required idle", name, tx_busy);
        end
    endtask

    task automatic pulse_clear();
        clearErrors = 1'b1;
        sync();
        clearErrors = 1'b0;
    endtask

    function automatic logic [15:0] gen_word(input int i, input logic [15:0] w0,
                                             input logic [15:0] w1, input logic [15:0] w2);
        if (i == 0) return w0;
        if (i == 1) return w1;
        if (i == 2) return w2;
        return {8'(i * 3), 8'(i * 7 + 1)};
    endfunction

    // Non-reflected MSB-first formulation; a good frame leaves the 802.3 residue.
    function automatic logic [31:0] residue(input int first, input int last);
        logic [31:0] c = 32'hFFFFFFFF;
        for (int k = first; k <= last; k++) begin
            logic [7:0] b;
            b = cap[k];
            for (int j = 0; j < 8; j++) begin
                logic fbk;
                fbk = c[31] ^ b[j];
                c = {c[30:0], 1'b0};
                if (fbk) c = c ^ 32'h04C11DB7;
            end
        end
        return c;
    endfunction

    function automatic logic [7:0] exp_payload(input int i, input int nb, input int wbase);
        logic [15:0] w;
        if (i >= nb) return 8'h00;
        w = sent_words[wbase + i / 2];
        return (i % 2 == 1) ? w[7:0] : w[15:8];
    endfunction

    task automatic check_frame(input string name, input int base, input int nb, input int wbase);
        int plen = (nb < 60) ? 60 : nb;
        int bad  = 0;
        int badx = -1;
        if (cap.size() >= base + 8 + plen + 4) begin
            for (int k = 0; k < 7; k++) if (cap[base + k] !== 8'h55) bad++;
            if (cap[base + 7] !== 8'hD5) bad++;
            check({name, " preamble/sfd errors"}, bad, 0);
            bad = 0;
            for (int i = 0; i < plen; i++) begin
                if (cap[base + 8 + i] !== exp_payload(i, nb, wbase)) begin
                    bad++;
                    if (badx < 0) badx = i;
                end
            end
            check({name, " payload byte errors"}, bad, 0);
            if (badx >= 0)
                check({name, " first bad payload byte"}, cap[base + 8 + badx], exp_payload(badx, nb, wbase));
            check({name, " fcs residue"}, residue(base + 8, base + 8 + plen + 3), 32'hC704DD7B);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset       = 1'b1;
        clearErrors = 1'b0;
        refresh();
        repeat (3) sync();
        check("reset tx_en", gmii_tx_en, 0);
        check("reset txd", gmii_txd, 0);
        check("reset tx_er", gmii_tx_er, 0);
        check("reset busy", tx_busy, 0);
        check("reset info_rd_en", send_info_rd_en, 0);
        check("reset send_rd_en", send_rd_en, 0);
        check("reset first_byte_error", first_byte_error, 0);
        check("reset underrun_error", underrun_error, 0);
        reset = 1'b0;
        sync();

        vecs[0] = '{32'h0012003C, 30, 16'h1234, 16'h5678, 16'h9ABC, 72, 30, 1'b0};
        vecs[1] = '{32'h00AA0005,  3, 16'hAABB, 16'hCCDD, 16'hEE99, 72,  3, 1'b0};
        vecs[2] = '{32'h00000000,  0, 16'h0000, 16'h0000, 16'h0000, 72,  0, 1'b0};
        vecs[3] = '{32'h00450040, 32, 16'h4546, 16'h0102, 16'h0304, 76, 32, 1'b0};
        vecs[4] = '{32'h80000010,  8, 16'h1111, 16'h2222, 16'h3333,  0,  8, 1'b0};
        vecs[5] = '{32'h00000003,  2, 16'h4500, 16'h6600, 16'h0000, 72,  2, 1'b1};

        for (int v = 0; v < 6; v++) begin
            string nm;
            nm = $sformatf("vec%0d", v);
            clear_cap();
            for (int i = 0; i < vecs[v].nwords; i++)
                push_word(gen_word(i, vecs[v].w0, vecs[v].w1, vecs[v].w2));
            iq.push_back(vecs[v].desc);
            refresh();
            wait_idle(nm);
            sync();
            check({nm, " tx_en cycles"}, cap.size(), vecs[v].exp_len);
            check({nm, " descriptor pops"}, ipops, 1);
            check({nm, " payload pops"}, pops, vecs[v].exp_pops);
            check({nm, " fifo drained"}, dq.size(), 0);
            if (vecs[v].exp_len > 0)
                check_frame(nm, 0, int'(vecs[v].desc[11:0]), 0);
            check({nm, " first_byte_error"}, first_byte_error, vecs[v].exp_fbe);
            check({nm, " underrun_error"}, underrun_error, 0);
            pulse_clear();
            check({nm, " flag after clear"}, first_byte_error, 0);
        end
`ifdef ETH_TX_STATS_EN
        check("stats numFlushed", tx_stats[31:24], 1);
        check("stats numUnderrun", tx_stats[23:16], 0);
        check("stats numSent", tx_stats[15:0], 5);
`endif

        // Underrun: 64-byte frame with only 10 words available up front.
        clear_cap();
        for (int i = 0; i < 10; i++) push_word(gen_word(i, 16'h0001, 16'h0203, 16'h0405));
        iq.push_back(32'h00000040);
        refresh();
        repeat (120) sync();
        begin
            int first_er = -1;
            int n_er = 0;
            for (int k = 0; k < er_cap.size(); k++) begin
                if (er_cap[k]) begin
                    n_er++;
                    if (first_er < 0) first_er = k;
                end
            end
            check("underrun tx_en cycles", cap.size(), 76);
            check("underrun first tx_er index", first_er, 28);
            check("underrun tx_er count", n_er, 44);
        end
        check("underrun flag", underrun_error, 1);
        check("underrun pops before drain", pops, 10);
        check("underrun busy while draining", tx_busy, 1);
        check("underrun first_byte_error", first_byte_error, 0);
        for (int i = 10; i < 32; i++) push_word(gen_word(i, 16'h0001, 16'h0203, 16'h0405));
        wait_idle("underrun drain");
        check("underrun total pops", pops, 32);
        check("underrun fifo drained", dq.size(), 0);
        check("underrun no new frame", cap.size(), 76);
`ifdef ETH_TX_STATS_EN
        check("stats underrun count", tx_stats[23:16], 1);
        check("stats flushed unchanged", tx_stats[31:24], 1);
`endif
        pulse_clear();
        check("underrun flag after clear", underrun_error, 0);

        // Back-to-back: two queued descriptors, second expects 0x00 but sees 0x45.
        clear_cap();
        push_word(16'h1234);
        push_word(16'h5678);
        push_word(16'h4546);
        iq.push_back(32'h00120004);
        iq.push_back(32'h00000002);
        refresh();
        for (int i = 0; i < 400 && rises.size() < 2; i++) sync();
        wait_idle("b2b");
        check("b2b frames seen", rises.size(), 2);
        if (rises.size() == 2)
            check("b2b preamble spacing", rises[1] - rises[0], 84);
        check("b2b total tx_en cycles", cap.size(), 144);
        check("b2b descriptor pops", ipops, 2);
        check("b2b payload pops", pops, 3);
        check_frame("b2b frame1", 0, 4, 0);
        check_frame("b2b frame2", 72, 2, 2);
        check("b2b first_byte_error", first_byte_error, 1);
        pulse_clear();

        // Reset in the middle of the payload.
        clear_cap();
        for (int i = 0; i < 16; i++) push_word(gen_word(i, 16'h1234, 16'h5678, 16'h9ABC));
        iq.push_back(32'h00770020);
        refresh();
        for (int i = 0; i < 100 && rises.size() == 0; i++) sync();
        repeat (12) sync();
        check("midreset in data tx_en", gmii_tx_en, 1);
        check("midreset fbe before reset", first_byte_error, 1);
        reset = 1'b1;
        sync();
        check("midreset tx_en", gmii_tx_en, 0);
        check("midreset busy", tx_busy, 0);
        check("midreset first_byte_error", first_byte_error, 0);
        check("midreset underrun_error", underrun_error, 0);
        check("midreset send_rd_en", send_rd_en, 0);
`ifdef ETH_TX_STATS_EN
        check("midreset stats", tx_stats, 0);
`endif
        reset = 1'b0;
        dq.delete();
        refresh();
        sync();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
